// File: rtl/sfp_link_ctrl_pkg.sv
// Shared state encodings, widths and per-state output decode for the SFP+ link sequencer.
package sfp_link_pkg;

    localparam int unsigned TIMER_W = 24;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLKWAIT  = 3'd1,
        S_TXON     = 3'd2,
        S_LINKWAIT = 3'd3,
        S_UP       = 3'd4,
        S_FAULT    = 3'd5,
        S_LOCKOUT  = 3'd6
    } state_e;

    typedef struct packed {
        logic tx_disable;
        logic pcs_rst;
        logic link_up;
        logic lockout;
    } out_t;

    localparam out_t OUT_SAFE     = '{tx_disable: 1'b1, pcs_rst: 1'b1, link_up: 1'b0, lockout: 1'b0};
    localparam out_t OUT_TXON     = '{tx_disable: 1'b0, pcs_rst: 1'b1, link_up: 1'b0, lockout: 1'b0};
    localparam out_t OUT_LINKWAIT = '{tx_disable: 1'b0, pcs_rst: 1'b0, link_up: 1'b0, lockout: 1'b0};
    localparam out_t OUT_UP       = '{tx_disable: 1'b0, pcs_rst: 1'b0, link_up: 1'b1, lockout: 1'b0};
    localparam out_t OUT_LOCKOUT  = '{tx_disable: 1'b1, pcs_rst: 1'b1, link_up: 1'b0, lockout: 1'b1};

    function automatic out_t state_outputs(state_e s);
        out_t o;
        case (s)
            S_TXON:     o = OUT_TXON;
            S_LINKWAIT: o = OUT_LINKWAIT;
            S_UP:       o = OUT_UP;
            S_LOCKOUT:  o = OUT_LOCKOUT;
            default:    o = OUT_SAFE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sfp_link_ctrl_if.sv
// Pin bundle between the board top and the SFP+ link sequencer.
// Defining SFP_LINK_STATS_EN adds the link_down_cnt / fault_cnt statistics outputs.
interface sfp_link_ctrl_if;
    logic        sfp_clk_alarm_b;
    logic        sfp_tx_fault;
    logic        sfp_rx_los;
    logic        pcs_block_lock;
    logic        clear_lockout;
    logic        sfp_tx_disable;
    logic        pcs_rst;
    logic        link_up;
    logic        lockout;
    logic [3:0]  retry_cnt;
    logic [2:0]  state_o;
`ifdef SFP_LINK_STATS_EN
    logic [15:0] link_down_cnt;
    logic [15:0] fault_cnt;

    modport master (
        output sfp_clk_alarm_b, sfp_tx_fault, sfp_rx_los, pcs_block_lock, clear_lockout,
        input  sfp_tx_disable, pcs_rst, link_up, lockout, retry_cnt, state_o,
        input  link_down_cnt, fault_cnt
    );
    modport slave (
        input  sfp_clk_alarm_b, sfp_tx_fault, sfp_rx_los, pcs_block_lock, clear_lockout,
        output sfp_tx_disable, pcs_rst, link_up, lockout, retry_cnt, state_o,
        output link_down_cnt, fault_cnt
    );
`else
    modport master (
        output sfp_clk_alarm_b, sfp_tx_fault, sfp_rx_los, pcs_block_lock, clear_lockout,
        input  sfp_tx_disable, pcs_rst, link_up, lockout, retry_cnt, state_o
    );
    modport slave (
        input  sfp_clk_alarm_b, sfp_tx_fault, sfp_rx_los, pcs_block_lock, clear_lockout,
        output sfp_tx_disable, pcs_rst, link_up, lockout, retry_cnt, state_o
    );
`endif
endinterface

// File: rtl/sfp_link_ctrl_debounce.sv
// Two-flop synchronizer plus stability filter: the output follows the synchronized
// input only after CYCLES consecutive disagreeing cycles.
module sfp_debounce #(
    parameter int unsigned CYCLES    = 1000,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o
);

    localparam int unsigned      CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            filt_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            if (sync_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout_o = filt_q;

endmodule

// File: rtl/sfp_link_ctrl.sv
// SFP+ 10G bring-up and fault sequencer; all decisions in the clk100 domain.
// Define SFP_LINK_STATS_EN to add saturating link-down and fault counters.
module sfp_link_ctrl
    import sfp_link_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned TX_ON_CYCLES    = 200000,
    parameter int unsigned LINK_TIMEOUT    = 5000000,
    parameter int unsigned FAULT_HOLD      = 1000000,
    parameter int unsigned MAX_RETRY       = 3
) (
    input  logic           clk100,
    input  logic           sys_rst_n,
    sfp_link_ctrl_if.slave sfp
);

    localparam logic [TIMER_W-1:0] TX_ON_LAST   = TIMER_W'(TX_ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LINK_TO_LAST = TIMER_W'(LINK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(FAULT_HOLD - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               alarm_ok;
    logic               fault_f;
    logic               los_f;
    logic               lock_meta_q;
    logic               lock_s_q;
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    out_t               out_q;

    sfp_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_alarm (
        .clk_i(clk100), .rst_ni(sys_rst_n), .din_i(sfp.sfp_clk_alarm_b), .dout_o(alarm_ok)
    );
    sfp_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_fault (
        .clk_i(clk100), .rst_ni(sys_rst_n), .din_i(sfp.sfp_tx_fault), .dout_o(fault_f)
    );
    sfp_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_los (
        .clk_i(clk100), .rst_ni(sys_rst_n), .din_i(sfp.sfp_rx_los), .dout_o(los_f)
    );

    // Block lock is already qualified by the PCS, so it is only synchronized.
    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= sfp.pcs_block_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_CLKWAIT;
            S_CLKWAIT: if (alarm_ok) state_d = S_TXON;
            S_TXON: begin
                if (fault_f)                  state_d = S_FAULT;
                else if (!alarm_ok)           state_d = S_CLKWAIT;
                else if (timer_q == TX_ON_LAST) state_d = S_LINKWAIT;
            end
            S_LINKWAIT: begin
                if (fault_f)                      state_d = S_FAULT;
                else if (!alarm_ok)               state_d = S_CLKWAIT;
                else if (!los_f && lock_s_q)      state_d = S_UP;
                else if (timer_q == LINK_TO_LAST) state_d = S_FAULT;
            end
            S_UP: begin
                if (fault_f)                state_d = S_FAULT;
                else if (!alarm_ok)         state_d = S_CLKWAIT;
                else if (los_f || !lock_s_q) state_d = S_LINKWAIT;
            end
            S_FAULT: begin
                if (timer_q == HOLD_LAST)
                    state_d = (retry_q == RETRY_LIMIT) ? S_LOCKOUT : S_CLKWAIT;
            end
            S_LOCKOUT: if (sfp.clear_lockout) state_d = S_CLKWAIT;
            default:   state_d = S_FAULT;
        endcase

        retry_d = retry_q;
        if (state_d == S_UP || (state_q == S_LOCKOUT && state_d == S_CLKWAIT))
            retry_d = '0;
        else if (state_q == S_FAULT && state_d == S_CLKWAIT && retry_q != '1)
            retry_d = retry_q + RETRY_W'(1);

        // Saturate rather than wrap so a long stay in a waiting state never aliases a timeout.
        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + TIMER_W'(1);
        else                     timer_d = timer_q;
    end

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
            out_q   <= OUT_SAFE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            out_q   <= state_outputs(state_d);
        end
    end

    assign sfp.sfp_tx_disable = out_q.tx_disable;
    assign sfp.pcs_rst        = out_q.pcs_rst;
    assign sfp.link_up        = out_q.link_up;
    assign sfp.lockout        = out_q.lockout;
    assign sfp.retry_cnt      = retry_q;
    assign sfp.state_o        = state_q;

`ifdef SFP_LINK_STATS_EN
    logic [15:0] link_down_cnt_q;
    logic [15:0] fault_cnt_q;

    always_ff @(posedge clk100 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            link_down_cnt_q <= '0;
            fault_cnt_q     <= '0;
        end else begin
            if (state_q == S_UP && state_d != S_UP && link_down_cnt_q != '1)
                link_down_cnt_q <= link_down_cnt_q + 16'd1;
            if (state_d == S_FAULT && state_q != S_FAULT && fault_cnt_q != '1)
                fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign sfp.link_down_cnt = link_down_cnt_q;
    assign sfp.fault_cnt     = fault_cnt_q;
`endif

endmodule
